// File: rtl/bios_port_arbiter_pkg.sv
// Shared constants and types for the two-requester BIOS read-port arbiter.
package bios_port_arbiter_pkg;
    localparam int BIOS_ADDR_W     = 12;
    localparam int BIOS_DATA_W     = 32;
    localparam int BIOS_ARB_NREQ   = 2;
    localparam int BIOS_ARB_ID_CPU = 0;
    localparam int BIOS_ARB_ID_DBG = 1;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;
endpackage

// File: rtl/bios_port_arbiter_if.sv
// Request/response channels of all requesters, packed per requester index.
interface bios_port_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             rsp_valid;
    logic [NREQ-1:0][DATA_W-1:0] rsp_data;
    logic [NREQ-1:0]             rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bios_port_arbiter_rsp_buf.sv
// One-entry response holding register; keeps data stable until the consumer takes it.
module bios_rsp_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    // A load on the same edge as a consume keeps valid high with the new word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/bios_port_arbiter.sv
// Round-robin sharing of the registered BIOS port-B read between the CPU load path
// and the debug/boot-loader reader, with per-requester response buffers.
module bios_port_arbiter
    import bios_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = BIOS_ADDR_W,
    parameter int DATA_W = BIOS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    bios_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] bios_adrb,
    input  logic [DATA_W-1:0] bios_doutb
);
    localparam int NREQ = BIOS_ARB_NREQ;

    logic [NREQ-1:0] pend, busy, elig, grant;
    req_id_e         rr_last;
    logic [ADDR_W-1:0] addr_hold;

    // A requester with a read in flight or an unconsumed response may not issue another.
    always_comb begin
        busy  = pend | (bus.rsp_valid & ~bus.rsp_ready);
        elig  = bus.req_valid & ~busy;
        grant = '0;
        if (reset) begin
            if (&elig) grant = (rr_last == REQ_DBG) ? 2'b01 : 2'b10;
            else       grant = elig;
        end
        bus.req_ready = grant;
    end

    // Without an accept the port address parks on the last one to avoid toggling the RAM.
    always_comb begin
        bios_adrb = addr_hold;
        if (!reset)        bios_adrb = '0;
        else if (grant[1]) bios_adrb = bus.req_addr[1];
        else if (grant[0]) bios_adrb = bus.req_addr[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= '0;
            rr_last   <= REQ_DBG;
            addr_hold <= '0;
        end else begin
            pend <= grant;
            if (|grant) begin
                rr_last   <= grant[1] ? REQ_DBG : REQ_CPU;
                addr_hold <= bios_adrb;
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        bios_rsp_buf #(.DATA_W(DATA_W)) u_rsp_buf (
            .clk     (clk),
            .reset   (reset),
            .load    (pend[i]),
            .data_in (bios_doutb),
            .ready   (bus.rsp_ready[i]),
            .valid   (bus.rsp_valid[i]),
            .data    (bus.rsp_data[i])
        );
    end
endmodule

// File: tb/tb_bios_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, port address and
// response timing; a monitor pops expected read data whenever a response is consumed.
module tb_bios_port_arbiter;
    import bios_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bios_port_arbiter_if #(.NREQ(BIOS_ARB_NREQ), .ADDR_W(BIOS_ADDR_W), .DATA_W(BIOS_DATA_W)) bus ();
    logic [BIOS_ADDR_W-1:0] bios_adrb;
    logic [BIOS_DATA_W-1:0] bios_doutb;

    bios_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .bios_adrb  (bios_adrb),
        .bios_doutb (bios_doutb)
    );

    // BIOS memory model: registered read, preloaded contents.
    logic [31:0] mem [0:4095];
    initial for (int a = 0; a < 4096; a++) mem[a] = 32'hB000_0000 | a;
    always @(posedge clk) bios_doutb <= mem[bios_adrb];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: per requester, whether a read is outstanding and when its data shows.
    bit          outst [2];
    int          rdy_cyc [2];
    int          rr_last_m;
    logic [11:0] hold_m;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [1:0]  m_ev, m_busy, m_elig, m_eg;
    logic [11:0] m_adr;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_adrb", 32'(bios_adrb), 32'h0);
            outst[0] = 0; outst[1] = 0;
            rr_last_m = 1;
            hold_m = '0;
            q0.delete(); q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ev[i]   = outst[i] && (cyc >= rdy_cyc[i]);
                m_busy[i] = outst[i] && !(m_ev[i] && bus.rsp_ready[i]);
            end
            m_elig = bus.req_valid & ~m_busy;
            if (m_elig == 2'b11) m_eg = (rr_last_m == 1) ? 2'b01 : 2'b10;
            else                 m_eg = m_elig;
            m_adr = m_eg[1] ? bus.req_addr[1] : (m_eg[0] ? bus.req_addr[0] : hold_m);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_ev));
            chk("req_ready", 32'(bus.req_ready), 32'(m_eg));
            chk("bios_adrb", 32'(bios_adrb), 32'(m_adr));
            for (int i = 0; i < 2; i++)
                if (m_ev[i] && bus.rsp_ready[i]) outst[i] = 0;
            for (int i = 0; i < 2; i++)
                if (m_eg[i]) begin
                    outst[i]   = 1;
                    rdy_cyc[i] = cyc + 2;
                    rr_last_m  = i;
                    hold_m     = m_adr;
                    if (i == 0) q0.push_back(32'hB000_0000 | 32'(m_adr));
                    else        q1.push_back(32'hB000_0000 | 32'(m_adr));
                end
        end
    end

    // Monitor: every consumed response must match the oldest expected word for that port.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 32'(bus.rsp_data[0]), 32'hDEAD_0000);
                else                chk("rsp0_data", bus.rsp_data[0], q0.pop_front());
            end
            if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 32'(bus.rsp_data[1]), 32'hDEAD_0001);
                else                chk("rsp1_data", bus.rsp_data[1], q1.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = 2'b11;
        step(3);

        // Contention straight out of reset: grants alternate starting with requester 0.
        reset = 1'b1;
        bus.req_valid   = 2'b11;
        bus.req_addr[0] = 12'h001;
        bus.req_addr[1] = 12'h002;
        step(10);
        bus.req_valid = '0;
        step(3);

        // Single read.
        bus.req_valid[0] = 1'b1;
        bus.req_addr[0]  = 12'h010;
        step(1);
        bus.req_valid = '0;
        step(4);

        // Backpressure on requester 1 while requester 0 streams.
        bus.req_valid[1] = 1'b1;
        bus.req_addr[1]  = 12'h055;
        step(1);
        bus.req_addr[1]  = 12'h056;
        bus.rsp_ready[1] = 1'b0;
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.req_addr[0] = 12'h020 + 12'(k);
            step(1);
        end
        bus.rsp_ready[1] = 1'b1;
        step(4);
        bus.req_valid = '0;
        step(4);

        // Idle hold after 0x3FF.
        bus.req_valid[0] = 1'b1;
        bus.req_addr[0]  = 12'h3FF;
        step(1);
        bus.req_valid = '0;
        step(6);

        // Reset with a read in flight; no stale response may follow.
        bus.req_valid[0] = 1'b1;
        bus.req_addr[0]  = 12'h123;
        step(1);
        bus.req_valid = '0;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(5);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            bus.req_valid   = 2'($urandom);
            bus.req_addr[0] = 12'($urandom);
            bus.req_addr[1] = 12'($urandom);
            bus.rsp_ready[0] = ($urandom_range(0, 9) < 7);
            bus.rsp_ready[1] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                step(2);
                reset = 1'b1;
            end
            step(1);
        end

        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        step(6);
        chk("drain_q0", 32'(q0.size()), 32'h0);
        chk("drain_q1", 32'(q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
